// File: rtl/hex_digit_sequencer.sv
// Hex digit sequencer: accepts a multi-nibble word over valid/ready and
// presents it one nibble at a time, most-significant first. Each digit is
// shown for DWELL cycles, with GAP blank cycles between digits.
module hex_digit_sequencer #(
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned DWELL       = 4,
  parameter int unsigned GAP         = 2,
  parameter bit          SUPPRESS_LZ = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic             load_ready,
  input  logic             repeat_en,
  output logic [3:0]       nibble,
  output logic             blank,
  output logic             dp,
  output logic             busy
);

  localparam int unsigned NDig   = WIDTH / 4;
  localparam int unsigned MaxCnt = (DWELL > GAP) ? DWELL : GAP;
  localparam int unsigned CntW   = $clog2(MaxCnt + 1);
  localparam int unsigned IdxW   = (NDig > 1) ? $clog2(NDig) : 1;

  // Counters hold "cycles remaining minus one", so a phase ends when they hit 0.
  localparam logic [CntW-1:0] DwellLoad = CntW'(DWELL - 1);
  localparam logic [CntW-1:0] GapLoad   = CntW'((GAP > 0) ? GAP - 1 : 0);

  typedef enum logic [1:0] {StIdle, StShow, StGap} state_e;

  state_e            state_q, state_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]  word_q, word_d;
  logic [3:0]        nibble_d;
  logic              blank_d, dp_d, busy_d;
  logic [WIDTH-1:0]  sel_word;

  // Index of the first digit to show; with suppression, the highest nonzero
  // nibble (0 for an all-zero word so the LS digit is always shown).
  function automatic logic [IdxW-1:0] first_digit(input logic [WIDTH-1:0] w);
    logic [IdxW-1:0] f;
    f = IdxW'(NDig - 1);
    if (SUPPRESS_LZ) begin
      f = '0;
      for (int i = 0; i < int'(NDig); i++) begin
        if (w[i*4 +: 4] != 4'h0) f = IdxW'(i);
      end
    end
    return f;
  endfunction

  assign load_ready = (state_q == StIdle);

  // State, datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      idx_q   <= '0;
      cnt_q   <= '0;
      word_q  <= '0;
      nibble  <= 4'h0;
      blank   <= 1'b1;
      dp      <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      nibble  <= nibble_d;
      blank   <= blank_d;
      dp      <= dp_d;
      busy    <= busy_d;
    end
  end

  // Next-state: dwell/gap countdown and digit stepping.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    word_d  = word_q;
    unique case (state_q)
      StIdle: begin
        if (load_valid) begin
          word_d  = load_data;
          idx_d   = first_digit(load_data);
          cnt_d   = DwellLoad;
          state_d = StShow;
        end
      end
      StShow: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if ((idx_q != '0) || repeat_en) begin
          if (GAP == 0) begin
            // No gap phase: step straight to the next (or first) digit.
            idx_d = (idx_q != '0) ? idx_q - 1'b1 : first_digit(word_q);
            cnt_d = DwellLoad;
          end else begin
            state_d = StGap;
            cnt_d   = GapLoad;
          end
        end else begin
          state_d = StIdle;
        end
      end
      StGap: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          // Leaving a gap after the LS digit means a repeat restart.
          state_d = StShow;
          idx_d   = (idx_q != '0) ? idx_q - 1'b1 : first_digit(word_q);
          cnt_d   = DwellLoad;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Output next-values derived from the next state; nibble holds outside SHOW.
  always_comb begin
    sel_word = word_d >> {idx_d, 2'b00};
    nibble_d = nibble;
    if (state_d == StShow) nibble_d = sel_word[3:0];
    blank_d = (state_d != StShow);
    dp_d    = (state_d == StShow) && (idx_d == '0);
    busy_d  = (state_d != StIdle);
  end

endmodule

// File: tb/tb_hex_digit_sequencer.sv
// Bench for hex_digit_sequencer: three parameterisations share clock/reset;
// expected per-cycle outputs are queued at load time and popped every cycle.
module tb_hex_digit_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  valid;
  logic [15:0] ld;
  logic        repeat_en;
  int          sel;

  logic       rdy_a, blank_a, dp_a, busy_a;
  logic       rdy_b, blank_b, dp_b, busy_b;
  logic       rdy_c, blank_c, dp_c, busy_c;
  logic [3:0] nib_a, nib_b, nib_c;
  logic [7:0] obs;

  always #5 clk = ~clk;

  // a: WIDTH=8 with suppression; b: WIDTH=8 no suppression; c: 16-bit, DWELL=1, GAP=0
  hex_digit_sequencer #(.WIDTH(8), .DWELL(4), .GAP(2), .SUPPRESS_LZ(1'b1)) u_a (
    .clk(clk), .reset(reset), .load_valid(valid[0]), .load_data(ld[7:0]),
    .load_ready(rdy_a), .repeat_en(repeat_en), .nibble(nib_a), .blank(blank_a),
    .dp(dp_a), .busy(busy_a)
  );
  hex_digit_sequencer #(.WIDTH(8), .DWELL(4), .GAP(2), .SUPPRESS_LZ(1'b0)) u_b (
    .clk(clk), .reset(reset), .load_valid(valid[1]), .load_data(ld[7:0]),
    .load_ready(rdy_b), .repeat_en(repeat_en), .nibble(nib_b), .blank(blank_b),
    .dp(dp_b), .busy(busy_b)
  );
  hex_digit_sequencer #(.WIDTH(16), .DWELL(1), .GAP(0), .SUPPRESS_LZ(1'b1)) u_c (
    .clk(clk), .reset(reset), .load_valid(valid[2]), .load_data(ld),
    .load_ready(rdy_c), .repeat_en(repeat_en), .nibble(nib_c), .blank(blank_c),
    .dp(dp_c), .busy(busy_c)
  );

  // Observed vector: {nibble, blank, dp, busy, load_ready}
  assign obs = (sel == 0) ? {nib_a, blank_a, dp_a, busy_a, rdy_a} :
               (sel == 1) ? {nib_b, blank_b, dp_b, busy_b, rdy_b} :
                            {nib_c, blank_c, dp_c, busy_c, rdy_c};

  logic [7:0] exp_q[$];
  logic [3:0] m_nib[3];
  int         checks = 0;
  int         errors = 0;
  int         step;
  string      tag;

  task automatic begin_test(input string name, input int s);
    tag  = name;
    step = 0;
    sel  = s;
  endtask

  // Expand a word into the expected per-cycle trace of the displayed digits.
  task automatic push_digits(input logic [15:0] w, input int nd, input int dwell,
                             input int gap, input bit slz, input bit trailing_gap);
    int         first;
    logic [3:0] d;
    first = nd - 1;
    if (slz) begin
      first = 0;
      for (int i = 0; i < nd; i++) if (((w >> (4 * i)) & 16'hF) != 16'h0) first = i;
    end
    for (int i = first; i >= 0; i--) begin
      d = 4'((w >> (4 * i)) & 16'hF);
      repeat (dwell) exp_q.push_back({d, 1'b0, (i == 0), 1'b1, 1'b0});
      m_nib[sel] = d;
      if (i > 0 || trailing_gap) repeat (gap) exp_q.push_back({d, 1'b1, 1'b0, 1'b1, 1'b0});
    end
  endtask

  task automatic push_idle();
    exp_q.push_back({m_nib[sel], 1'b1, 1'b0, 1'b0, 1'b1});
  endtask

  task automatic drain(input int n);
    logic [7:0] e;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $error("FAIL %s[%0d]: scoreboard empty, observed=%h", tag, step, obs);
      end else begin
        e = exp_q.pop_front();
        assert (obs === e) else begin
          errors++;
          $error("FAIL %s[%0d]: observed=%h expected=%h", tag, step, obs, e);
        end
      end
      step++;
    end
  endtask

  // Present a word to the selected DUT; caller drains the first cycle, then drops valid.
  task automatic start_load(input logic [15:0] w);
    ld         = w;
    valid      = '0;
    valid[sel] = 1'b1;
  endtask

  initial begin
    reset     = 1'b1;
    valid     = '0;
    ld        = '0;
    repeat_en = 1'b0;
    sel       = 0;
    for (int s = 0; s < 3; s++) m_nib[s] = 4'h0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    for (int s = 0; s < 3; s++) begin
      begin_test("reset_state", s);
      push_idle();
      drain(1);
    end

    begin_test("a5_basic", 0);
    push_digits(16'h00A5, 2, 4, 2, 1'b1, 1'b0);
    push_idle();
    start_load(16'h00A5);
    drain(1);
    valid = '0;
    drain(exp_q.size());

    begin_test("lz_05", 0);
    push_digits(16'h0005, 2, 4, 2, 1'b1, 1'b0);
    push_idle();
    start_load(16'h0005);
    drain(1);
    valid = '0;
    drain(exp_q.size());

    begin_test("lz_00", 0);
    push_digits(16'h0000, 2, 4, 2, 1'b1, 1'b0);
    push_idle();
    start_load(16'h0000);
    drain(1);
    valid = '0;
    drain(exp_q.size());

    begin_test("nolz_05", 1);
    push_digits(16'h0005, 2, 4, 2, 1'b0, 1'b0);
    push_idle();
    start_load(16'h0005);
    drain(1);
    valid = '0;
    drain(exp_q.size());

    begin_test("repeat_a5", 0);
    repeat_en = 1'b1;
    push_digits(16'h00A5, 2, 4, 2, 1'b1, 1'b1);
    push_digits(16'h00A5, 2, 4, 2, 1'b1, 1'b0);
    push_idle();
    start_load(16'h00A5);
    drain(1);
    valid = '0;
    drain(13);
    repeat_en = 1'b0;
    drain(exp_q.size());

    begin_test("busy_load", 0);
    push_digits(16'h00A5, 2, 4, 2, 1'b1, 1'b0);
    push_idle();
    push_digits(16'h003C, 2, 4, 2, 1'b1, 1'b0);
    push_idle();
    start_load(16'h00A5);
    drain(1);
    valid = '0;
    drain(1);
    start_load(16'h003C);
    drain(9);
    drain(1);
    valid = '0;
    drain(exp_q.size());

    begin_test("gap0_1234", 2);
    push_digits(16'h1234, 4, 1, 0, 1'b1, 1'b0);
    push_idle();
    start_load(16'h1234);
    drain(1);
    valid = '0;
    drain(exp_q.size());

    begin_test("reset_mid_show", 0);
    push_digits(16'h00A5, 2, 4, 2, 1'b1, 1'b0);
    start_load(16'h00A5);
    drain(1);
    valid = '0;
    drain(2);
    exp_q.delete();
    reset = 1'b1;
    for (int s = 0; s < 3; s++) m_nib[s] = 4'h0;
    push_idle();
    push_idle();
    drain(2);
    reset = 1'b0;
    repeat (3) push_idle();
    drain(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
